// File: rtl/rcvbuf_stream.sv
// rcvbuf_stream: store-and-forward receive buffer. Collects DATA_W-bit words from the
// RX holding register into a word memory. Once DEPTH_WORDS words are stored, it
// drains every stored bit LSB-first onto databit, one bit per bit_en strobe.
// Optional feature: define RCVBUF_FLUSH_EN to add the flush port, which lets a
// partially filled buffer start draining early.
module rcvbuf_stream #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned DEPTH_WORDS = 1250,
  parameter int unsigned CNT_W       = $clog2(DEPTH_WORDS + 1)
) (
  input  logic              rcvbuf_clk,
  input  logic              rst_n,
  input  logic              newdata,
  input  logic [DATA_W-1:0] rbr,
  input  logic              bit_en,
`ifdef RCVBUF_FLUSH_EN
  input  logic              flush,
`endif
  output logic              databit,
  output logic              ack,
  output logic              rfd,
  output logic              rx_full,
  output logic              rx_empty,
  output logic              start,
  output logic              ovr,
  output logic [CNT_W-1:0]  fill_level
);

  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
  localparam int unsigned BIT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {StFill, StFull, StDrain} state_e;

  state_e            state_q;
  logic              sync1_q, sync2_q, edge_q;
  logic              word_evt;
  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [ADDR_W-1:0] word_q;
  logic [BIT_W-1:0]  bit_q;

  logic              databit_q, ack_q, rfd_q, rx_full_q, rx_empty_q, start_q, ovr_q;
  logic [CNT_W-1:0]  fill_level_q;

  logic              last_bit;
  logic [ADDR_W-1:0] nxt_word;
  logic [BIT_W-1:0]  nxt_bit;
  logic              nxt_databit;
  logic [ADDR_W-1:0] last_word;
  logic              fill_last;
  logic              flush_go;

  assign databit    = databit_q;
  assign ack        = ack_q;
  assign rfd        = rfd_q;
  assign rx_full    = rx_full_q;
  assign rx_empty   = rx_empty_q;
  assign start      = start_q;
  assign ovr        = ovr_q;
  assign fill_level = fill_level_q;

  // newdata may be asynchronous: two-flop synchroniser plus edge register.
  always_ff @(posedge rcvbuf_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= newdata;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign word_evt  = sync2_q & ~edge_q;
  assign fill_last = (fill_level_q == CNT_W'(DEPTH_WORDS - 1));

`ifdef RCVBUF_FLUSH_EN
  // After a flush the drain stops at the last word actually written.
  assign last_word = ADDR_W'(fill_level_q - CNT_W'(1));
  assign flush_go  = flush & (word_evt | (fill_level_q != '0));
`else
  assign last_word = ADDR_W'(DEPTH_WORDS - 1);
  assign flush_go  = 1'b0;
`endif

  // Next drain position and the bit stored there.
  always_comb begin
    last_bit    = (bit_q == BIT_W'(DATA_W - 1));
    nxt_word    = last_bit ? word_q + ADDR_W'(1) : word_q;
    nxt_bit     = last_bit ? '0 : bit_q + BIT_W'(1);
    nxt_databit = mem_q[nxt_word][nxt_bit];
  end

  // Word memory: written only while filling, never reset.
  always_ff @(posedge rcvbuf_clk) begin
    if (state_q == StFill && word_evt) begin
      mem_q[fill_level_q[ADDR_W-1:0]] <= rbr;
    end
  end

  // Fill/drain state machine with registered outputs.
  always_ff @(posedge rcvbuf_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFill;
      databit_q    <= 1'b0;
      ack_q        <= 1'b0;
      rfd_q        <= 1'b1;
      rx_full_q    <= 1'b0;
      rx_empty_q   <= 1'b0;
      start_q      <= 1'b0;
      ovr_q        <= 1'b0;
      fill_level_q <= '0;
      word_q       <= '0;
      bit_q        <= '0;
    end else begin
      ack_q      <= 1'b0;
      rx_empty_q <= 1'b0;
      unique case (state_q)
        StFill: begin
          if (word_evt) begin
            ack_q        <= 1'b1;
            fill_level_q <= fill_level_q + CNT_W'(1);
          end
          // A flush in the same cycle as a word sees that word already written.
          if ((word_evt && fill_last) || flush_go) begin
            state_q   <= StFull;
            rx_full_q <= 1'b1;
            rfd_q     <= 1'b0;
          end
        end
        StFull: begin
          if (bit_en) begin
            state_q   <= StDrain;
            start_q   <= 1'b1;
            databit_q <= mem_q[0][0];
            word_q    <= '0;
            bit_q     <= '0;
          end
        end
        StDrain: begin
          if (bit_en) begin
            if (word_q == last_word && last_bit) begin
              state_q      <= StFill;
              databit_q    <= 1'b0;
              start_q      <= 1'b0;
              rx_full_q    <= 1'b0;
              rfd_q        <= 1'b1;
              fill_level_q <= '0;
              rx_empty_q   <= 1'b1;
              ovr_q        <= 1'b0;
              word_q       <= '0;
              bit_q        <= '0;
            end else begin
              databit_q <= nxt_databit;
              word_q    <= nxt_word;
              bit_q     <= nxt_bit;
            end
          end
        end
        default: state_q <= StFill;
      endcase
      // Words arriving while not filling are dropped; a drop beats the end-of-drain clear.
      if (word_evt && state_q != StFill) begin
        ovr_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/rcvbuf_stream.md
# rcvbuf_stream

Parametrised store-and-forward receive buffer, successor to the fixed 10K-bit flop-chain receive buffer. It takes DATA_W-bit words from the RS-232 RX holding register and stores DEPTH_WORDS of them in an addressed word memory rather than a shift chain. When the buffer is full it serialises all stored bits, LSB-first, into the main communication loopback, one bit per `bit_en` strobe. It runs on a single clock domain and adds overrun reporting and a fill-level output.

## Interface
- `DATA_W`, 8, bits per received word (≥2).
- `DEPTH_WORDS`, 1250, words stored before draining (≥2); total drained bits = DEPTH_WORDS*DATA_W.
- `CNT_W`, $clog2(DEPTH_WORDS+1), width of word counters and `fill_level`.
- `rcvbuf_clk`  input  1  sole clock, rising edge; every input is sampled on it.
- `rst_n`  input  1  reset, asynchronous assert, active-low.
- `newdata`  input  1  RX word-ready level; may be asynchronous to `rcvbuf_clk`.
- `rbr`  input  DATA_W  RX holding register; stable from `newdata` rise until `ack`.
- `bit_en`  input  1  one-cycle loopback bit-rate strobe (1200 Hz equivalent).
- `flush`  input  1  early-drain request; present only with RCVBUF_FLUSH_EN.
- `databit`  output  1  serial output into the loopback.
- `ack`  output  1  one-cycle pulse: `rbr` captured.
- `rfd`  output  1  ready for data.
- `rx_full`  output  1  buffer full or draining.
- `rx_empty`  output  1  one-cycle pulse: drain complete.
- `start`  output  1  high while draining; alerts TX buffer.
- `ovr`  output  1  sticky overrun: a word arrived while `rfd`=0.
- `fill_level`  output  CNT_W  words currently stored.

## Operation
- Reset values: `databit`=0, `ack`=0, `rfd`=1, `rx_full`=0, `rx_empty`=0, `start`=0, `ovr`=0, `fill_level`=0, state FILL. Memory contents are not cleared and are don't-care.
- `newdata` passes through a 2-flop synchroniser plus an edge register. A word event is a synchronised 0→1 edge; a held level produces exactly one event.
- FILL: on each event, write `rbr` to mem[`fill_level`], increment `fill_level`, and pulse `ack`. When `fill_level` reaches DEPTH_WORDS, go to FULL, set `rx_full`=1 and `rfd`=0 on that same edge. `bit_en` is ignored.
- FULL: wait for `bit_en`. On it: DRAIN, `start`=1, `databit`=word0 bit0.
- DRAIN: each `bit_en` presents the next bit in order word0 bit0…bit DATA_W-1, then word1, and so on. Each bit is held for exactly one `bit_en` period. On the `bit_en` after the final bit:
  - `databit`=0, `start`=0, `rx_full`=0, `rfd`=1, `fill_level`=0;
  - `rx_empty` pulses; `ovr` clears;
  - state returns to FILL.
- Any word event outside FILL: the word is dropped, no `ack`, `ovr`=1.
- Reset mid-operation: immediate return to reset values. A partially drained buffer is discarded.
- Bit and word counters never wrap. All compares are against DEPTH_WORDS-1 and DATA_W-1 exactly.

## Timing
- `newdata` rising before edge k: `ack`=1 and the memory write happen at edge k+2. `fill_level` updates on the same edge.
- Last word: `rx_full`, `rfd`=0 and state FULL occur on the same edge as its `ack`.
- Drain latency: the first `bit_en` seen in FULL is the edge that drives bit0 (registered, one-edge).
- An event in the same cycle as the FILL→FULL transition can only be the filling word. Later events count as overrun.
- `databit` is registered and changes only on `bit_en` edges or reset.

## Configuration
- `RCVBUF_FLUSH_EN` defined:
  - A `flush`=1 sample in FILL with `fill_level`>0 moves to FULL as if full (`rx_full`=1, `rfd`=0).
  - DRAIN then emits `fill_level`*DATA_W bits and completes normally.
  - `flush` with `fill_level`=0, or outside FILL, is ignored.
  - A word event and `flush` in the same cycle: the word is written first, then the flush takes effect.
- `RCVBUF_FLUSH_EN` undefined: the `flush` port is absent and draining starts only at DEPTH_WORDS.

## Test plan
All scenarios use DATA_W=8, DEPTH_WORDS=4 unless noted.
- Reset: assert `rst_n`=0 mid-DRAIN → all outputs return to reset values within the same cycle. Next word → `ack` at k+2, `fill_level`=1.
- Fill: send 0xA5, 0x3C, 0xFF, 0x01 → four `ack` pulses. `rx_full`=1 and `rfd`=0 on the fourth. `fill_level`=4.
- Drain: after the fill above, apply 33 `bit_en` strobes → `databit` sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1×8, 1,0,0,0,0,0,0,0. `start` is high for those 32 periods. On strobe 33: `rx_empty` pulses and `databit`=0.
- Overrun: send a word while `rx_full`=1 → no `ack`, `ovr`=1, drained data unchanged. `ovr` clears with `rx_empty`.
- Level hold: hold `newdata`=1 for 100 cycles → exactly one `ack`, `fill_level`=1.
- Flush (with `RCVBUF_FLUSH_EN`): 2 words 0x81, 0x7E then `flush` → 16 bits drained (1,0,0,0,0,0,0,1, 0,1,1,1,1,1,1,0), then `rx_empty`.
